alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the 8-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered result with a full flag set (Z, N, C, V). It adds arithmetic shift right, a compare, and an iterative unsigned multiply that returns a double-width product. It sits between the register file and the writeback stage of the RISC datapath; the decoder drives the opcode, and writeback consumes the result when OValid pulses.

## Interface
- W, 8: datapath width in bits; legal range 4..32.
- ICLK  in  1  clock; all state changes on the rising edge.
- IRSTn  in  1  reset; asynchronous, active-low.
- IValid  in  1  operands and opcode are valid this cycle.
- ORdy  out  1  block can accept an operation; reset value 1.
- IRa  in  W  operand A.
- IRb  in  W  operand B.
- IOPALU  in  4  opcode.
- OValid  out  1  one-cycle pulse: result and flags are updated; reset value 0.
- OALUD  out  W  result, or low half of the product; reset value 0.
- OALUH  out  W  high half of the product for MUL, 0 for every other op; reset value 0.
- OFgz, OFgn, OFgc, OFgv  out  1 each  zero, negative, carry/borrow and signed-overflow flags; reset value 0.

## Operation
- An operation is accepted on a rising edge where IValid=1 and ORdy=1. IRa, IRb and IOPALU are captured at that edge.
- Opcodes and their results:
  - 0 NOP: result 0.
  - 1 ADD: IRa+IRb. C = carry out. V = signed overflow.
  - 2 SUB: IRa-IRb. C = borrow (IRa<IRb, unsigned). V = signed overflow.
  - 3 NAND: bitwise ~(IRa&IRb). C=0, V=0.
  - 4 SHL: IRa<<1. C = IRa[W-1]. V=0.
  - 5 SHR: logical IRa>>1. C = IRa[0]. V=0.
  - 6 ASR: arithmetic IRa>>1 (sign bit replicated). C = IRa[0]. V=0.
  - 7 MUL: unsigned product, {OALUH,OALUD} = IRa*IRb.
  - 8 CMP: computes SUB flags only; OALUD = 0.
  - 9–15: treated as NOP.
- Flag rules for opcodes 1–6:
  - Z = (OALUD==0).
  - N = OALUD[W-1].
- Flag rules for CMP: Z, N, C and V are all taken from the internal IRa-IRb.
- Flag rules for MUL:
  - Z = (2W-bit product==0).
  - N = 0, V = 0.
  - C = (OALUH!=0).
- NOP and illegal opcodes clear all flags and OALUH. They still produce an OValid pulse.
- State machine: IDLE, MUL_BUSY.
  - IDLE: ORdy=1. Accepting opcodes 0–6 or 8 writes the outputs at the same edge. Accepting MUL loads the multiplier and moves to MUL_BUSY.
  - MUL_BUSY: ORdy=0. Radix-2 shift-add, one multiplier bit per cycle, with an iteration counter of clog2(W+1) bits. IValid is ignored and no operation is accepted.
  - When the counter reaches W, outputs and flags are written, OValid is asserted, and the FSM returns to IDLE.
- OALUD, OALUH and the flags hold their values between results. They change only on edges where OValid is written 1.

## Timing
- Single-cycle ops: the operation is accepted at edge k; results and OValid=1 are visible after edge k. OValid falls after edge k+1 unless a new op is accepted at edge k+1.
- Throughput is one op per cycle. ORdy stays 1 across back-to-back single-cycle ops.
- MUL: accepted at edge k; ORdy=0 after edges k..k+W-1. Results and OValid=1 appear after edge k+W; ORdy=1 again after edge k+W. Latency is W cycles.
- ORdy does not combinationally depend on IValid.
- Reset asserted at any time, including mid-MUL, immediately does the following:
  - forces IDLE;
  - clears the counter and partial product;
  - sets all outputs to their reset values.
- After reset release, the first edge with IValid=1 is accepted.
- Simultaneous IValid=1 and final MUL iteration: the op is not accepted, because ORdy is still 0 in that cycle.

## Structure
- Package alu_pkg: opcode constants OP_NOP..OP_CMP and state encoding ST_IDLE/ST_MUL.
- Sub-module alu_mul_seq: iterative shift-add multiplier with a start/done interface, parametrised by W. The top level holds the FSM, the single-cycle datapath, the flag logic and the output registers.

## Test plan
- W=8, back-to-back ADD 0x7F+0x01, then SUB 0x00-0x01, with IValid held high:
  - first result: OALUD=0x80, N=1, V=1, C=0, Z=0;
  - second result: OALUD=0xFF, N=1, C=1, V=0;
  - one OValid per cycle, ORdy constant 1.
- SUB 0x05-0x05 -> OALUD=0x00, Z=1, C=0.
- CMP 0x03,0x07 -> OALUD=0x00, C=1, N=1, Z=0.
- Shifts:
  - SHL 0x81 -> 0x02, C=1;
  - SHR 0x01 -> 0x00, Z=1, C=1;
  - ASR 0x80 -> 0xC0, N=1, C=0.
- MUL 0xFF*0xFF:
  - ORdy low for exactly 8 cycles;
  - OALUH=0xFE, OALUD=0x01, C=1, Z=0;
  - a second IValid during busy is not accepted and is retried correctly once ORdy=1.
- IRSTn pulsed low during MUL iteration 4:
  - all outputs are 0 and ORdy=1 immediately;
  - a following ADD 0x02+0x03 returns OALUD=0x05 one cycle after acceptance.
- Opcode 0xC with any operands -> OValid pulse, OALUD=0, OALUH=0, all flags 0. Repeat the ADD case at W=16: 0x7FFF+0x0001 -> 0x8000, V=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_NAND = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ASR  = 4'd6,
    OP_MUL  = 4'd7,
    OP_CMP  = 4'd8
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam flags_t FLAGS_CLR = '0;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, W cycles
// per product. done_o marks the cycle whose edge performs the final step, and
// product_o carries the finished product during that cycle.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  logic [W-1:0]   mcand_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic [W:0]     add_ext;
  logic [2*W-1:0] step;

  // One shift-add step: conditionally add the multiplicand to the high half,
  // then shift {carry, hi, lo} right by one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    add_ext = {1'b0, hi_q};
    if (lo_q[0]) begin
      add_ext = {1'b0, hi_q} + {1'b0, mcand_q};
    end
    step = {add_ext, lo_q[W-1:1]};
  end

  assign done_o    = busy_q && (cnt_q == LAST_STEP);
  assign product_o = step;

  // Load operands on start, then iterate until W steps have been taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the partial product and counter are reset too, so an abort mid-multiply leaves no stale state behind.
    if (!rst_ni) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      mcand_q <= a_i;
      hi_q    <= '0;
      lo_q    <= b_i;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      hi_q  <= step[2*W-1:W];
      lo_q  <= step[W-1:0];
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST_STEP) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready input and a one-cycle OValid result pulse.
// Single-cycle ops write their result at the accepting edge; MUL runs on the
// iterative multiplier and writes its double-width product W cycles later.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         ICLK,
  input  logic         IRSTn,
  input  logic         IValid,
  output logic         ORdy,
  input  logic [W-1:0] IRa,
  input  logic [W-1:0] IRb,
  input  logic [3:0]   IOPALU,
  output logic         OValid,
  output logic [W-1:0] OALUD,
  output logic [W-1:0] OALUH,
  output logic         OFgz,
  output logic         OFgn,
  output logic         OFgc,
  output logic         OFgv
);

  state_e         state_q;
  logic           rdy_q;
  logic           valid_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   hi_q;
  flags_t         flags_q;

  logic [W:0]     add_ext;
  logic [W:0]     sub_ext;
  logic           add_v;
  logic           sub_v;
  logic [W-1:0]   res_d;
  flags_t         flg_d;
  logic           zn_from_res;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  flags_t         mul_flg;

  // Shared adder/subtractor with the carry (or borrow) in bit W.
  assign add_ext = {1'b0, IRa} + {1'b0, IRb};
  assign sub_ext = {1'b0, IRa} - {1'b0, IRb};
  assign add_v   = (IRa[W-1] == IRb[W-1]) && (add_ext[W-1] != IRa[W-1]);
  assign sub_v   = (IRa[W-1] != IRb[W-1]) && (sub_ext[W-1] != IRa[W-1]);

  // Single-cycle datapath: result and flags for every opcode except MUL.
  always_comb begin
    res_d       = '0;
    flg_d       = FLAGS_CLR;
    zn_from_res = 1'b0;
    case (IOPALU)
      OP_ADD: begin
        res_d       = add_ext[W-1:0];
        flg_d.c     = add_ext[W];
        flg_d.v     = add_v;
        zn_from_res = 1'b1;
      end
      OP_SUB: begin
        res_d       = sub_ext[W-1:0];
        flg_d.c     = sub_ext[W];
        flg_d.v     = sub_v;
        zn_from_res = 1'b1;
      end
      OP_NAND: begin
        res_d       = ~(IRa & IRb);
        zn_from_res = 1'b1;
      end
      OP_SHL: begin
        res_d       = {IRa[W-2:0], 1'b0};
        flg_d.c     = IRa[W-1];
        zn_from_res = 1'b1;
      end
      OP_SHR: begin
        res_d       = {1'b0, IRa[W-1:1]};
        flg_d.c     = IRa[0];
        zn_from_res = 1'b1;
      end
      OP_ASR: begin
        res_d       = {IRa[W-1], IRa[W-1:1]};
        flg_d.c     = IRa[0];
        zn_from_res = 1'b1;
      end
      OP_CMP: begin
        flg_d.z = (sub_ext[W-1:0] == '0);
        flg_d.n = sub_ext[W-1];
        flg_d.c = sub_ext[W];
        flg_d.v = sub_v;
      end
      default: ;  // NOP and unused opcodes: zero result, flags cleared
    endcase
    if (zn_from_res) begin
      flg_d.z = (res_d == '0);
      flg_d.n = res_d[W-1];
    end
  end

  // Flags for a finished product: Z over all 2W bits, C when the high half is in use.
  always_comb begin
    mul_flg   = FLAGS_CLR;
    mul_flg.z = (mul_prod == '0);
    mul_flg.c = (mul_prod[2*W-1:W] != '0);
  end

  // The ready output is registered and only high in IDLE, so acceptance is just IValid in IDLE.
  assign mul_start = (state_q == ST_IDLE) && IValid && (IOPALU == OP_MUL);

  alu_mul_seq #(.W(W)) u_mul (
    .clk_i     (ICLK),
    .rst_ni    (IRSTn),
    .start_i   (mul_start),
    .a_i       (IRa),
    .b_i       (IRb),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Control FSM with registered ready, valid pulse and held result/flag outputs.
  always_ff @(posedge ICLK or negedge IRSTn) begin
    if (!IRSTn) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= FLAGS_CLR;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (IValid) begin
            if (IOPALU == OP_MUL) begin
              state_q <= ST_MUL;
              rdy_q   <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              res_q   <= res_d;
              hi_q    <= '0;
              flags_q <= flg_d;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            valid_q <= 1'b1;
            res_q   <= mul_prod[W-1:0];
            hi_q    <= mul_prod[2*W-1:W];
            flags_q <= mul_flg;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign ORdy   = rdy_q;
  assign OValid = valid_q;
  assign OALUD  = res_q;
  assign OALUH  = hi_q;
  assign OFgz   = flags_q.z;
  assign OFgn   = flags_q.n;
  assign OFgc   = flags_q.c;
  assign OFgv   = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at W=8 and W=16: directed cases plus random operations,
// checked by a scoreboard fed from an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=8 instance
  logic       rst8_n, v8, rdy8, ov8, z8, n8, c8, vf8;
  logic [3:0] op8;
  logic [7:0] a8, b8, d8, h8;
  // W=16 instance
  logic        rst16_n, v16, rdy16, ov16, z16, n16, c16, vf16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, d16, h16;

  alu_seq #(.W(8)) dut8 (
    .ICLK(clk), .IRSTn(rst8_n), .IValid(v8), .ORdy(rdy8),
    .IRa(a8), .IRb(b8), .IOPALU(op8), .OValid(ov8),
    .OALUD(d8), .OALUH(h8), .OFgz(z8), .OFgn(n8), .OFgc(c8), .OFgv(vf8)
  );

  alu_seq #(.W(16)) dut16 (
    .ICLK(clk), .IRSTn(rst16_n), .IValid(v16), .ORdy(rdy16),
    .IRa(a16), .IRb(b16), .IOPALU(op16), .OValid(ov16),
    .OALUD(d16), .OALUH(h16), .OFgz(z16), .OFgn(n16), .OFgc(c16), .OFgv(vf16)
  );

  typedef struct {
    int              op;
    longint unsigned a, b, res, hi;
    logic [3:0]      flg;  // {Z, N, C, V}
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic longint sgn(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  function automatic bit ovf(input longint s, input int w);
    longint lim = longint'(1) << (w - 1);
    return (s >= lim) || (s < -lim);
  endfunction

  // Reference model: results straight from the arithmetic definition of each opcode.
  function automatic exp_t model(input int w, input int op, input longint unsigned a, input longint unsigned b);
    exp_t e;
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned p;
    bit z = 0, n = 0, c = 0, v = 0;
    e.op = op; e.a = a; e.b = b; e.res = 0; e.hi = 0;
    case (op)
      1: begin e.res = (a + b) & m; c = (a + b) > m; v = ovf(sgn(a, w) + sgn(b, w), w); end
      2: begin e.res = (a - b) & m; c = a < b;       v = ovf(sgn(a, w) - sgn(b, w), w); end
      3: e.res = ~(a & b) & m;
      4: begin e.res = (a << 1) & m; c = ((a >> (w - 1)) & 1) != 0; end
      5: begin e.res = a >> 1;       c = (a & 1) != 0; end
      6: begin e.res = $unsigned(sgn(a, w) >>> 1) & m; c = (a & 1) != 0; end
      7: begin
        p = a * b;
        e.res = p & m; e.hi = p >> w;
        z = (p == 0); c = (e.hi != 0);
      end
      8: begin
        c = a < b; v = ovf(sgn(a, w) - sgn(b, w), w);
        z = (a == b); n = ((((a - b) & m) >> (w - 1)) & 1) != 0;
      end
      default: ;
    endcase
    if (op >= 1 && op <= 6) begin
      z = (e.res == 0);
      n = ((e.res >> (w - 1)) & 1) != 0;
    end
    e.flg = {z, n, c, v};
    return e;
  endfunction

  // Present an op (IValid left high on return), wait for ORdy, record the
  // expectation and return at the falling edge after the accepting edge.
  task automatic send(input int sel, input int op, input longint unsigned a, input longint unsigned b,
                      output int waited);
    exp_t e;
    e = model(sel ? 16 : 8, op, a, b);
    if (sel == 0) begin v8 = 1'b1; op8 = 4'(op); a8 = 8'(a); b8 = 8'(b); end
    else begin v16 = 1'b1; op16 = 4'(op); a16 = 16'(a); b16 = 16'(b); end
    waited = 0;
    while (!(sel ? rdy16 : rdy8) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) fail_now($sformatf("ready_timeout w%0d op%0d", sel ? 16 : 8, op));
    else if (sel == 0) q8.push_back(e);
    else q16.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int sel);
    if (sel == 0) v8 = 1'b0; else v16 = 1'b0;
  endtask

  // Check the outputs currently on the DUT against hand-derived constants.
  task automatic expect_now(input int sel, input string tag, input logic [63:0] res,
                            input logic [63:0] hi, input logic [3:0] flg);
    if (sel == 0) begin
      check({tag, "_valid"}, 64'(ov8), 64'd1);
      check({tag, "_res"}, 64'(d8), res);
      check({tag, "_hi"}, 64'(h8), hi);
      check({tag, "_flags"}, 64'({z8, n8, c8, vf8}), 64'(flg));
    end else begin
      check({tag, "_valid"}, 64'(ov16), 64'd1);
      check({tag, "_res"}, 64'(d16), res);
      check({tag, "_hi"}, 64'(h16), hi);
      check({tag, "_flags"}, 64'({z16, n16, c16, vf16}), 64'(flg));
    end
  endtask

  task automatic pop_check(input int sel);
    exp_t  e;
    string tag;
    if ((sel == 0 && q8.size() == 0) || (sel == 1 && q16.size() == 0)) begin
      fail_now($sformatf("unexpected_ovalid w%0d", sel ? 16 : 8));
      return;
    end
    e = (sel == 0) ? q8.pop_front() : q16.pop_front();
    tag = $sformatf("sb w%0d op%0d a=%0h b=%0h", sel ? 16 : 8, e.op, e.a, e.b);
    if (sel == 0) begin
      check({tag, " res"}, 64'(d8), 64'(e.res));
      check({tag, " hi"}, 64'(h8), 64'(e.hi));
      check({tag, " flags"}, 64'({z8, n8, c8, vf8}), 64'(e.flg));
    end else begin
      check({tag, " res"}, 64'(d16), 64'(e.res));
      check({tag, " hi"}, 64'(h16), 64'(e.hi));
      check({tag, " flags"}, 64'({z16, n16, c16, vf16}), 64'(e.flg));
    end
  endtask

  // Monitor: every OValid pulse consumes exactly one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ov8 === 1'b1) pop_check(0);
      if (ov16 === 1'b1) pop_check(1);
    end
  end

  function automatic longint unsigned pick(input longint unsigned m);
    case ($urandom_range(0, 5))
      0: return 0;
      1: return m;
      2: return m >> 1;
      3: return (m >> 1) + 1;
      default: return longint'($urandom) & m;
    endcase
  endfunction

  initial begin
    int w;
    int n;
    rst8_n = 1'b0; rst16_n = 1'b0;
    v8 = 0; op8 = 0; a8 = 0; b8 = 0;
    v16 = 0; op16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_rdy8", 64'(rdy8), 64'd1);
    check("rst_ovalid8", 64'(ov8), 64'd0);
    check("rst_out8", 64'({h8, d8, z8, n8, c8, vf8}), 64'd0);
    check("rst_rdy16", 64'(rdy16), 64'd1);
    check("rst_out16", 64'({ov16, h16, d16, z16, n16, c16, vf16}), 64'd0);
    rst8_n = 1'b1; rst16_n = 1'b1;

    // Back-to-back ADD then SUB with IValid held high
    send(0, 1, 'h7F, 'h01, w);
    check("b2b_add_wait", 64'(w), 64'd0);
    expect_now(0, "add_7f_01", 'h80, 0, 4'b0101);
    check("b2b_rdy_1", 64'(rdy8), 64'd1);
    send(0, 2, 'h00, 'h01, w);
    check("b2b_sub_wait", 64'(w), 64'd0);
    expect_now(0, "sub_00_01", 'hFF, 0, 4'b0110);
    check("b2b_rdy_2", 64'(rdy8), 64'd1);
    idle(0);
    @(negedge clk);
    check("ovalid_drops", 64'(ov8), 64'd0);
    check("held_res", 64'(d8), 64'hFF);

    send(0, 2, 'h05, 'h05, w); expect_now(0, "sub_eq", 'h00, 0, 4'b1000);
    send(0, 8, 'h03, 'h07, w); expect_now(0, "cmp_3_7", 'h00, 0, 4'b0110);
    send(0, 4, 'h81, 'h00, w); expect_now(0, "shl_81", 'h02, 0, 4'b0010);
    send(0, 5, 'h01, 'h00, w); expect_now(0, "shr_01", 'h00, 0, 4'b1010);
    send(0, 6, 'h80, 'h00, w); expect_now(0, "asr_80", 'hC0, 0, 4'b0100);
    idle(0);

    // MUL 0xFF*0xFF: ORdy low for exactly W cycles, then the product
    @(negedge clk);
    send(0, 7, 'hFF, 'hFF, w);
    idle(0);
    n = 0;
    while (!rdy8 && n < 100) begin
      check("mul_no_early_valid", 64'(ov8), 64'd0);
      n++;
      @(negedge clk);
    end
    check("mul_rdy_low_cycles", 64'(n), 64'd8);
    expect_now(0, "mul_ff_ff", 'h01, 'hFE, 4'b0010);

    // Op held during MUL busy is retried and accepted only once ORdy returns
    send(0, 7, 'hC3, 'h5A, w);
    send(0, 1, 'h11, 'h22, w);
    check("retry_wait_cycles", 64'(w), 64'd8);
    expect_now(0, "retry_add", 'h33, 0, 4'b0000);
    idle(0);
    @(negedge clk);

    // Reset during MUL iteration 4
    send(0, 7, 'hA5, 'h5A, w);
    idle(0);
    repeat (3) @(negedge clk);
    rst8_n = 1'b0;
    #1;
    check("midmul_rst_rdy", 64'(rdy8), 64'd1);
    check("midmul_rst_out", 64'({ov8, h8, d8, z8, n8, c8, vf8}), 64'd0);
    q8.delete();
    @(negedge clk);
    rst8_n = 1'b1;
    send(0, 1, 'h02, 'h03, w);
    expect_now(0, "post_rst_add", 'h05, 0, 4'b0000);

    // Illegal opcode clears everything left by a flag-setting op
    send(0, 2, 'h00, 'h01, w);
    send(0, 12, 'hA7, 'h3C, w);
    expect_now(0, "op_c", 'h00, 0, 4'b0000);
    idle(0);

    // Random traffic on the 8-bit instance
    for (int i = 0; i < 300; i++) begin
      send(0, int'($urandom_range(0, 15)), pick('hFF), pick('hFF), w);
      if ($urandom_range(0, 3) == 0) begin
        idle(0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    idle(0);

    // W=16
    send(1, 1, 'h7FFF, 'h0001, w);
    expect_now(1, "add16_7fff_1", 'h8000, 0, 4'b0101);
    send(1, 7, 'hFFFF, 'hFFFF, w);
    idle(1);
    n = 0;
    while (!rdy16 && n < 100) begin n++; @(negedge clk); end
    check("mul16_rdy_low_cycles", 64'(n), 64'd16);
    for (int i = 0; i < 120; i++) begin
      send(1, int'($urandom_range(0, 15)), pick('hFFFF), pick('hFFFF), w);
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        @(negedge clk);
      end
    end
    idle(1);

    // Drain outstanding results
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
